// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage with IF/ID register and one-entry skid buffer
module if_stage #(
  parameter int          INST_W   = 19,
  parameter int          PC_W     = 8,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              is_stall,
  input  logic              branch_taken,
  input  logic [PC_W-1:0]   branch_target,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_ready,
  input  logic [INST_W-1:0] imem_rdata,
  output logic [INST_W-1:0] if_inst,
  output logic [PC_W-1:0]   if_pc,
  output logic [PC_W-1:0]   if_pc_plus1,
  output logic              if_valid
);

  typedef enum logic [1:0] {BOOT, FETCH, DISCARD} state_t;

  state_t              state;
  logic [PC_W-1:0]     pc;
  logic [PC_W-1:0]     pending_target;
  logic [INST_W-1:0]   skid;
  logic [PC_W-1:0]     skid_pc;
  logic                skid_valid;

  assign imem_req    = ((state == FETCH) && !skid_valid) || (state == DISCARD);
  assign imem_addr   = pc;
  assign if_pc_plus1 = if_pc + PC_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= BOOT;
      pc             <= PC_W'(RESET_PC);
      pending_target <= '0;
      skid           <= '0;
      skid_pc        <= '0;
      skid_valid     <= 1'b0;
      if_inst        <= '0;
      if_pc          <= '0;
      if_valid       <= 1'b0;
    end else begin
      case (state)
        BOOT: state <= FETCH;

        FETCH: begin
          if (branch_taken) begin
            // Redirect beats stall and skid; a still-outstanding request must be drained first.
            if_inst    <= '0;
            if_valid   <= 1'b0;
            skid_valid <= 1'b0;
            if (imem_req && !imem_ready) begin
              pending_target <= branch_target;
              state          <= DISCARD;
            end else begin
              pc <= branch_target;
            end
          end else if (skid_valid) begin
            if (!is_stall) begin
              if_inst    <= skid;
              if_pc      <= skid_pc;
              if_valid   <= 1'b1;
              skid_valid <= 1'b0;
            end
          end else if (imem_ready) begin
            pc <= pc + PC_W'(1);
            if (is_stall) begin
              skid       <= imem_rdata;
              skid_pc    <= pc;
              skid_valid <= 1'b1;
            end else begin
              if_inst  <= imem_rdata;
              if_pc    <= pc;
              if_valid <= 1'b1;
            end
          end else if (!is_stall) begin
            // Nothing returned: insert a bubble, keeping if_inst zero when invalid.
            if_inst  <= '0;
            if_valid <= 1'b0;
          end
        end

        DISCARD: begin
          if_inst  <= '0;
          if_valid <= 1'b0;
          if (branch_taken) pending_target <= branch_target;
          if (imem_ready) begin
            pc    <= branch_taken ? branch_target : pending_target;
            state <= FETCH;
          end
        end

        default: state <= BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - directed self-checking bench for if_stage
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        is_stall;
  logic        branch_taken;
  logic [7:0]  branch_target;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ready;
  logic [18:0] imem_rdata;
  logic [18:0] if_inst;
  logic [7:0]  if_pc;
  logic [7:0]  if_pc_plus1;
  logic        if_valid;

  int vectors = 0;
  int errors  = 0;

  if_stage #(.INST_W(19), .PC_W(8), .RESET_PC(0)) dut (
    .clk(clk), .rst_n(rst_n), .is_stall(is_stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .if_inst(if_inst), .if_pc(if_pc), .if_pc_plus1(if_pc_plus1),
    .if_valid(if_valid)
  );

  always #5 clk = ~clk;

  // Memory word at address a is {3'b101, 8'h00, a}
  function automatic logic [18:0] pat(input logic [7:0] a);
    return {3'b101, 8'h00, a};
  endfunction

  assign imem_rdata = pat(imem_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_if(input string tag, input logic v, input logic [7:0] pc);
    chk({tag, "_valid"}, 32'(if_valid), 32'(v));
    if (v) begin
      chk({tag, "_pc"}, 32'(if_pc), 32'(pc));
      chk({tag, "_inst"}, 32'(if_inst), 32'(pat(pc)));
    end else begin
      chk({tag, "_inst0"}, 32'(if_inst), 32'd0);
    end
  endtask

  initial begin
    rst_n = 1'b1; is_stall = 1'b0; branch_taken = 1'b0;
    branch_target = 8'h00; imem_ready = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    chk("rst_pc", 32'(if_pc), 32'd0);
    chk_if("rst", 1'b0, 8'h00);
    tick; tick;
    rst_n = 1'b1;
    #1 chk("boot_req", 32'(imem_req), 32'd0);

    // Zero-wait memory streaming
    tick;
    chk("fetch_req", 32'(imem_req), 32'd1);
    chk("fetch_addr", 32'(imem_addr), 32'd0);
    chk_if("first", 1'b0, 8'h00);
    for (int k = 0; k < 4; k++) begin
      tick;
      chk_if("stream", 1'b1, 8'(k));
      chk("stream_plus1", 32'(if_pc_plus1), 32'(k + 1));
    end

    // Two-cycle latency with stall while @5 returns
    imem_ready = 1'b0; tick;
    chk_if("lat_bubble", 1'b0, 8'h00);
    chk("lat_addr", 32'(imem_addr), 32'd4);
    imem_ready = 1'b1; tick;
    chk_if("lat_4", 1'b1, 8'd4);
    imem_ready = 1'b0; is_stall = 1'b1; tick;
    chk_if("stall_hold1", 1'b1, 8'd4);
    chk("stall_addr5", 32'(imem_addr), 32'd5);
    imem_ready = 1'b1; tick;
    chk_if("stall_hold2", 1'b1, 8'd4);
    chk("skid_req0", 32'(imem_req), 32'd0);
    chk("skid_addr6", 32'(imem_addr), 32'd6);
    tick;
    chk_if("stall_hold3", 1'b1, 8'd4);
    chk("skid_req0b", 32'(imem_req), 32'd0);
    is_stall = 1'b0; imem_ready = 1'b0; tick;
    chk_if("drain5", 1'b1, 8'd5);
    chk("drain_req", 32'(imem_req), 32'd1);
    tick;
    chk_if("drain_bubble", 1'b0, 8'h00);
    imem_ready = 1'b1; tick;
    chk_if("fetch6", 1'b1, 8'd6);

    // Branch while @7 is outstanding (three-cycle latency)
    imem_ready = 1'b0; branch_taken = 1'b1; branch_target = 8'h40; tick;
    branch_taken = 1'b0;
    chk_if("br_flush", 1'b0, 8'h00);
    chk("br_addr_hold", 32'(imem_addr), 32'd7);
    chk("br_req", 32'(imem_req), 32'd1);
    tick;
    chk("br_addr_hold2", 32'(imem_addr), 32'd7);
    imem_ready = 1'b1; tick;
    chk_if("br_drop", 1'b0, 8'h00);
    chk("br_addr_new", 32'(imem_addr), 32'h40);
    tick;
    chk_if("br_target", 1'b1, 8'h40);

    // Branch with stall and full skid
    is_stall = 1'b1; tick;
    chk("skid2_req0", 32'(imem_req), 32'd0);
    chk_if("skid2_hold", 1'b1, 8'h40);
    branch_taken = 1'b1; branch_target = 8'hFE; tick;
    branch_taken = 1'b0; is_stall = 1'b0;
    chk_if("brst_flush", 1'b0, 8'h00);
    chk("brst_req", 32'(imem_req), 32'd1);
    chk("brst_addr", 32'(imem_addr), 32'hFE);

    // PC wrap
    tick;
    chk_if("wrap_fe", 1'b1, 8'hFE);
    chk("wrap_fe_p1", 32'(if_pc_plus1), 32'hFF);
    tick;
    chk_if("wrap_ff", 1'b1, 8'hFF);
    chk("wrap_ff_p1", 32'(if_pc_plus1), 32'h00);
    tick;
    chk_if("wrap_00", 1'b1, 8'h00);

    // Asynchronous reset with skid full
    is_stall = 1'b1; tick;
    chk("pre_rst_req", 32'(imem_req), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_req", 32'(imem_req), 32'd0);
    chk("arst_addr", 32'(imem_addr), 32'd0);
    chk("arst_pc", 32'(if_pc), 32'd0);
    chk_if("arst", 1'b0, 8'h00);
    is_stall = 1'b0;
    tick;
    rst_n = 1'b1;
    #1 chk("reboot_req", 32'(imem_req), 32'd0);
    tick;
    chk("refetch_req", 32'(imem_req), 32'd1);
    chk("refetch_addr", 32'(imem_addr), 32'd0);
    tick;
    chk_if("refetch0", 1'b1, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
